// File: rtl/cpu_defs.sv
// Shared CPU definitions: bus widths, instruction-register field positions, fetch FSM encoding.
// Pure declarations; no timing or backpressure.
package cpu_defs;

  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 16;
  localparam int MAX_WAIT_DEF = 15;

  localparam int IR_I_BIT    = 15;
  localparam int IR_OPC_HI   = 14;
  localparam int IR_OPC_LO   = 12;
  localparam int IR_AFLD_HI  = 11;
  localparam int IR_AFLD_LO  = 0;

  localparam logic [1:0] FS_IDLE  = 2'd0;
  localparam logic [1:0] FS_READ  = 2'd1;
  localparam logic [1:0] FS_DRAIN = 2'd2;
  localparam logic [1:0] FS_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = FS_IDLE,
    S_READ  = FS_READ,
    S_DRAIN = FS_DRAIN,
    S_HOLD  = FS_HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts cycles a memory read has been outstanding; timeout_o flags the last permitted cycle.
// Combinational timeout from registered count; clr_i has priority over en_i.
module fetch_watchdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic REST_N,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q equals cycles already waited, so MAX_WAIT-1 marks the MAX_WAIT-th waiting cycle.
  assign timeout_o = en_i && (cnt_q == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !timeout_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge REST_N) begin
    if (!REST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC address -> shared-bus read -> IR with valid/taken handshake, PC_EN pulse on capture.
// MEM_RD one cycle after FETCH_REQ; IR_VALID/PC_EN the cycle after MEM_ACK; stalls on MEM_BUSY/IR_VALID.
module instr_fetch
  import cpu_defs::*;
#(
  parameter int ADDR_W   = cpu_defs::ADDR_W,
  parameter int DATA_W   = cpu_defs::DATA_W,
  parameter int MAX_WAIT = cpu_defs::MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              REST_N,
  input  logic [ADDR_W-1:0] PC_ADDR,
  output logic              PC_EN,
  input  logic              FETCH_REQ,
  input  logic              FLUSH,
  input  logic              MEM_BUSY,
  output logic              MEM_RD,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [DATA_W-1:0] IR_OUT,
  output logic              IR_I,
  output logic [2:0]        IR_OPC,
  output logic [11:0]       IR_AFLD,
  output logic              IR_VALID,
  input  logic              IR_TAKEN,
  output logic              BUS_ERR
);

  fetch_state_e      state_q, state_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_vld_q, ir_vld_d;
  logic              pc_en_q, pc_en_d;
  logic              bus_err_q, bus_err_d;
  logic              wd_clr, wd_en, wd_timeout;

  assign wd_en = (state_q == S_READ) || (state_q == S_DRAIN);

  fetch_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk       (clk),
    .REST_N    (REST_N),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .timeout_o (wd_timeout)
  );

  always_comb begin
    state_d    = state_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_vld_d   = ir_vld_q;
    pc_en_d    = 1'b0;
    bus_err_d  = bus_err_q;
    wd_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (FETCH_REQ && !MEM_BUSY && !FLUSH && !bus_err_q) begin
          mem_addr_d = PC_ADDR;
          mem_rd_d   = 1'b1;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        // An ACK in the final permitted cycle still counts as in time.
        if (MEM_ACK) begin
          mem_rd_d = 1'b0;
          if (!FLUSH) begin
            ir_d     = MEM_RDATA;
            ir_vld_d = 1'b1;
            pc_en_d  = 1'b1;
            state_d  = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wd_timeout) begin
          bus_err_d = 1'b1;
          mem_rd_d  = 1'b0;
          state_d   = S_IDLE;
        end else if (FLUSH) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (MEM_ACK) begin
          mem_rd_d = 1'b0;
          state_d  = S_IDLE;
        end else if (wd_timeout) begin
          bus_err_d = 1'b1;
          mem_rd_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_HOLD: begin
        if (FLUSH || IR_TAKEN) begin
          ir_vld_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    wd_clr = (state_d != state_q) && ((state_d == S_READ) || (state_d == S_DRAIN));
  end

  always_ff @(posedge clk or negedge REST_N) begin
    if (!REST_N) begin
      state_q    <= S_IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      ir_vld_q   <= 1'b0;
      pc_en_q    <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_vld_q   <= ir_vld_d;
      pc_en_q    <= pc_en_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // A branch load in the capture cycle must win over the increment.
  assign PC_EN    = pc_en_q & ~FLUSH;
  assign MEM_RD   = mem_rd_q;
  assign MEM_ADDR = mem_addr_q;
  assign IR_OUT   = ir_q;
  assign IR_VALID = ir_vld_q;
  assign BUS_ERR  = bus_err_q;
  assign IR_I     = ir_q[IR_I_BIT];
  assign IR_OPC   = ir_q[IR_OPC_HI:IR_OPC_LO];
  assign IR_AFLD  = ir_q[IR_AFLD_HI:IR_AFLD_LO];

endmodule
